// File: rtl/i2c_bus_detector.sv
// I2C bus front end: synchronizes and deglitches raw SCL/SDA, produces
// registered SCL edge pulses, START/STOP pulses, a bus-busy flag and an
// SCL-low timeout that returns a stuck bus to idle.
module i2c_bus_detector #(
    parameter int FILTER_LEN     = 4,      // 1..15
    parameter int TIMEOUT_CYCLES = 65535   // 1..2^20-1
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic scl_raw_i,
    input  logic sda_raw_i,
    output logic scl_o,
    output logic sda_o,
    output logic edge_detect_o,
    output logic scl_fall_o,
    output logic start_detected_o,
    output logic stop_detected_o,
    output logic bus_busy_o,
    output logic timeout_o
);

    localparam logic [0:0]  ST_IDLE    = 1'b0;
    localparam logic [0:0]  ST_BUSY    = 1'b1;
    // Counter value at which one more mismatching clock commits the new level.
    localparam logic [3:0]  FILT_LAST  = 4'(FILTER_LEN - 1);
    localparam logic [19:0] TO_LAST    = 20'(TIMEOUT_CYCLES - 1);

    logic [1:0]  scl_sync_q, sda_sync_q;
    logic [3:0]  scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
    logic        scl_filt_q, scl_filt_d, sda_filt_q, sda_filt_d;
    logic        scl_d_q, sda_d_q;
    logic [0:0]  state_q, state_d;
    logic [19:0] tcnt_q, tcnt_d;
    logic        timeout_d;
    logic        rise_c, fall_c, start_c, stop_c;

    // Two-stage synchronizers; idle bus is high, so they reset to 1.
    // NOTE: every register in an always_ff uses <= so all flops sample the
    // pre-edge values; a blocking = here would collapse the synchronizer chain.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_raw_i};
            sda_sync_q <= {sda_sync_q[0], sda_raw_i};
        end
    end

    // SCL filter: count consecutive clocks of disagreement, commit on the last one.
    // NOTE: defaults at the top of every always_comb keep all paths assigned,
    // so no latches are inferred.
    always_comb begin
        scl_cnt_d  = scl_cnt_q;
        scl_filt_d = scl_filt_q;
        if (scl_sync_q[1] == scl_filt_q) begin
            scl_cnt_d = '0;
        end else if (scl_cnt_q == FILT_LAST) begin
            scl_filt_d = scl_sync_q[1];
            scl_cnt_d  = '0;
        end else begin
            scl_cnt_d = scl_cnt_q + 4'd1;
        end
    end

    // SDA filter: identical behaviour to the SCL filter.
    always_comb begin
        sda_cnt_d  = sda_cnt_q;
        sda_filt_d = sda_filt_q;
        if (sda_sync_q[1] == sda_filt_q) begin
            sda_cnt_d = '0;
        end else if (sda_cnt_q == FILT_LAST) begin
            sda_filt_d = sda_sync_q[1];
            sda_cnt_d  = '0;
        end else begin
            sda_cnt_d = sda_cnt_q + 4'd1;
        end
    end

    // Filter state plus one-clock-delayed copies used for edge detection.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scl_cnt_q  <= '0;
            sda_cnt_q  <= '0;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
            scl_d_q    <= 1'b1;
            sda_d_q    <= 1'b1;
        end else begin
            scl_cnt_q  <= scl_cnt_d;
            sda_cnt_q  <= sda_cnt_d;
            scl_filt_q <= scl_filt_d;
            sda_filt_q <= sda_filt_d;
            scl_d_q    <= scl_filt_q;
            sda_d_q    <= sda_filt_q;
        end
    end

    // Bus conditions. START/STOP require SCL stable high across both samples,
    // so an SDA change landing with an SCL edge never qualifies.
    assign rise_c  =  scl_filt_q & ~scl_d_q;
    assign fall_c  = ~scl_filt_q &  scl_d_q;
    assign start_c = ~sda_filt_q &  sda_d_q & scl_filt_q & scl_d_q;
    assign stop_c  =  sda_filt_q & ~sda_d_q & scl_filt_q & scl_d_q;

    // Bus state and SCL-low timeout counter.
    always_comb begin
        state_d   = state_q;
        tcnt_d    = '0;
        timeout_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_c) state_d = ST_BUSY;
            end
            ST_BUSY: begin
                if (start_c) begin
                    state_d = ST_BUSY;
                end else if (stop_c) begin
                    state_d = ST_IDLE;
                end else if (!scl_filt_q) begin
                    if (tcnt_q == TO_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        tcnt_d = tcnt_q + 20'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Registered pulses, state and timeout counter.
    // NOTE: only control/status flops exist here, so a full reset is cheap;
    // there is no storage array that would need to be left unreset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q          <= ST_IDLE;
            tcnt_q           <= '0;
            edge_detect_o    <= 1'b0;
            scl_fall_o       <= 1'b0;
            start_detected_o <= 1'b0;
            stop_detected_o  <= 1'b0;
            timeout_o        <= 1'b0;
        end else begin
            state_q          <= state_d;
            tcnt_q           <= tcnt_d;
            edge_detect_o    <= rise_c;
            scl_fall_o       <= fall_c;
            start_detected_o <= start_c;
            stop_detected_o  <= stop_c;
            timeout_o        <= timeout_d;
        end
    end

    assign scl_o      = scl_filt_q;
    assign sda_o      = sda_filt_q;
    assign bus_busy_o = (state_q == ST_BUSY);

endmodule

// File: tb/tb_i2c_bus_detector.sv
// Self-checking bench for i2c_bus_detector (FILTER_LEN=4, TIMEOUT_CYCLES=100).
// Each stimulus step pushes the pulse it should cause and the cycle it is
// due; a monitor on the falling clock edge pops and compares.
module tb_i2c_bus_detector;

    localparam int FL  = 4;
    localparam int TO  = 100;
    localparam int LAT = FL + 3;  // raw change to pulse visible: 2 sync + FL filter + 1 register

    localparam logic [4:0] P_START = 5'b10000;
    localparam logic [4:0] P_STOP  = 5'b01000;
    localparam logic [4:0] P_RISE  = 5'b00100;
    localparam logic [4:0] P_FALL  = 5'b00010;
    localparam logic [4:0] P_TO    = 5'b00001;

    logic clk = 1'b0;
    logic rst_n, scl_raw, sda_raw;
    logic scl_o, sda_o, edge_detect_o, scl_fall_o;
    logic start_detected_o, stop_detected_o, bus_busy_o, timeout_o;
    logic [4:0] pulses;

    typedef struct {
        logic [4:0] pulses;
        int         at;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   cyc    = 0;

    i2c_bus_detector #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .scl_raw_i       (scl_raw),
        .sda_raw_i       (sda_raw),
        .scl_o           (scl_o),
        .sda_o           (sda_o),
        .edge_detect_o   (edge_detect_o),
        .scl_fall_o      (scl_fall_o),
        .start_detected_o(start_detected_o),
        .stop_detected_o (stop_detected_o),
        .bus_busy_o      (bus_busy_o),
        .timeout_o       (timeout_o)
    );

    assign pulses = {start_detected_o, stop_detected_o, edge_detect_o, scl_fall_o, timeout_o};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every observed pulse must match the queue head.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                checks++;
                $display("FAIL missed_pulse: expected pulses %b at cycle %0d, not observed by cycle %0d",
                         exp_q[0].pulses, exp_q[0].at, cyc);
                void'(exp_q.pop_front());
            end
            if (pulses !== 5'b0) begin
                checks++;
                if (exp_q.size() > 0 && exp_q[0].at == cyc && exp_q[0].pulses === pulses) begin
                    passes++;
                    void'(exp_q.pop_front());
                end else if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                    $display("FAIL pulse_value: got %b at cycle %0d, expected %b",
                             pulses, cyc, exp_q[0].pulses);
                    void'(exp_q.pop_front());
                end else begin
                    $display("FAIL unexpected_pulse: got %b at cycle %0d, next expected %0d entries queued",
                             pulses, cyc, exp_q.size());
                end
            end
        end
    end

    task automatic push(input logic [4:0] p, input int at);
        exp_q.push_back('{pulses: p, at: at});
    endtask

    task automatic set_lines(input logic scl, input logic sda);
        @(negedge clk);
        scl_raw = scl;
        sda_raw = sda;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        scl_raw = 1'b1;
        sda_raw = 1'b1;
        idle(3);
        checks++;
        if ({scl_o, sda_o, bus_busy_o, pulses} !== 8'b110_00000)
            $display("FAIL reset_values: got scl/sda/busy/pulses %b expected %b",
                     {scl_o, sda_o, bus_busy_o, pulses}, 8'b110_00000);
        else passes++;
        rst_n = 1'b1;
        idle(10);
        checks++;
        if ({scl_o, sda_o, bus_busy_o} !== 3'b110)
            $display("FAIL post_reset_idle: got %b expected 110", {scl_o, sda_o, bus_busy_o});
        else passes++;
    endtask

    // SCL high, SDA falls: sda_o at clock FL+2, START and busy at clock LAT.
    task automatic test_start;
        int c;
        set_lines(1'b1, 1'b0);
        c = cyc;
        push(P_START, c + LAT);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k >= 5 && k <= 8) begin
                checks++;
                if (sda_o !== logic'(k < FL + 2))
                    $display("FAIL start_sda_o k=%0d: got %b expected %b", k, sda_o, logic'(k < FL + 2));
                else passes++;
                checks++;
                if (bus_busy_o !== logic'(k >= LAT))
                    $display("FAIL start_busy k=%0d: got %b expected %b", k, bus_busy_o, logic'(k >= LAT));
                else passes++;
            end
        end
    endtask

    // SDA glitch too short to pass, then a 4-clock SCL high pulse.
    task automatic test_glitch_clock;
        int   c;
        logic moved;
        set_lines(1'b0, 1'b0);
        c = cyc;
        push(P_FALL, c + LAT);
        idle(9);
        set_lines(1'b0, 1'b1);
        idle(2);
        set_lines(1'b0, 1'b0);
        moved = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (sda_o !== 1'b0) moved = 1'b1;
        end
        checks++;
        if (moved !== 1'b0) $display("FAIL glitch_filtered: sda_o moved %b expected 0", moved);
        else passes++;
        set_lines(1'b1, 1'b0);
        c = cyc;
        push(P_RISE, c + LAT);
        idle(3);
        set_lines(1'b0, 1'b0);
        push(P_FALL, c + 4 + LAT);
        idle(12);
    endtask

    // Repeated START keeps busy; STOP drops busy in the same clock as its pulse.
    task automatic test_restart_stop;
        int   c;
        logic dropped;
        set_lines(1'b0, 1'b1);
        idle(8);
        set_lines(1'b1, 1'b1);
        c = cyc;
        push(P_RISE, c + LAT);
        idle(8);
        set_lines(1'b1, 1'b0);
        c = cyc;
        push(P_START, c + LAT);
        dropped = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (bus_busy_o !== 1'b1) dropped = 1'b1;
        end
        checks++;
        if (dropped !== 1'b0) $display("FAIL restart_busy_held: dropped %b expected 0", dropped);
        else passes++;
        set_lines(1'b1, 1'b1);
        c = cyc;
        push(P_STOP, c + LAT);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == LAT - 1 || k == LAT) begin
                checks++;
                if (bus_busy_o !== logic'(k < LAT))
                    $display("FAIL stop_busy k=%0d: got %b expected %b", k, bus_busy_o, logic'(k < LAT));
                else passes++;
            end
        end
    endtask

    // SCL stuck low while busy: timeout 100 clocks after scl_o falls, no STOP.
    task automatic test_timeout;
        int   c;
        logic raised;
        set_lines(1'b1, 1'b0);
        c = cyc;
        push(P_START, c + LAT);
        idle(9);
        set_lines(1'b0, 1'b0);
        c = cyc;
        push(P_FALL, c + LAT);
        push(P_TO, c + FL + 2 + TO);
        for (int k = 1; k <= FL + 2 + TO + 30; k++) begin
            @(negedge clk);
            if (k == FL + 2) begin
                checks++;
                if (scl_o !== 1'b0) $display("FAIL timeout_scl_low: got %b expected 0", scl_o);
                else passes++;
            end
            if (k == FL + 1 + TO || k == FL + 2 + TO) begin
                checks++;
                if (bus_busy_o !== logic'(k == FL + 1 + TO))
                    $display("FAIL timeout_busy k=%0d: got %b expected %b",
                             k, bus_busy_o, logic'(k == FL + 1 + TO));
                else passes++;
            end
        end
        // Recover the bus; a STOP seen in idle still pulses.
        set_lines(1'b1, 1'b0);
        c = cyc;
        push(P_RISE, c + LAT);
        idle(9);
        set_lines(1'b1, 1'b1);
        c = cyc;
        push(P_STOP, c + LAT);
        raised = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (bus_busy_o !== 1'b0) raised = 1'b1;
        end
        checks++;
        if (raised !== 1'b0) $display("FAIL idle_stop_busy: raised %b expected 0", raised);
        else passes++;
    endtask

    // Both lines fall together from idle: SCL fall only, no START.
    task automatic test_simultaneous;
        int   c;
        logic raised;
        set_lines(1'b0, 1'b0);
        c = cyc;
        push(P_FALL, c + LAT);
        raised = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (bus_busy_o !== 1'b0) raised = 1'b1;
        end
        checks++;
        if (raised !== 1'b0) $display("FAIL simul_busy: raised %b expected 0", raised);
        else passes++;
        set_lines(1'b1, 1'b1);
        c = cyc;
        push(P_RISE, c + LAT);
        idle(9);
    endtask

    // Reset mid-byte aborts at once; release with lines low filters down quietly.
    task automatic test_reset_mid;
        int   c;
        logic noisy;
        set_lines(1'b1, 1'b0);
        c = cyc;
        push(P_START, c + LAT);
        idle(9);
        set_lines(1'b0, 1'b0);
        c = cyc;
        push(P_FALL, c + LAT);
        idle(9);
        set_lines(1'b1, 1'b0);
        idle(2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({scl_o, sda_o, bus_busy_o, pulses} !== 8'b110_00000)
            $display("FAIL reset_mid_values: got %b expected %b",
                     {scl_o, sda_o, bus_busy_o, pulses}, 8'b110_00000);
        else passes++;
        scl_raw = 1'b1;
        sda_raw = 1'b1;
        idle(3);
        rst_n = 1'b1;
        noisy = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (pulses !== 5'b0 || bus_busy_o !== 1'b0) noisy = 1'b1;
        end
        checks++;
        if (noisy !== 1'b0) $display("FAIL reset_release_quiet: activity %b expected 0", noisy);
        else passes++;
        @(negedge clk);
        rst_n   = 1'b0;
        scl_raw = 1'b0;
        sda_raw = 1'b0;
        idle(2);
        @(negedge clk);
        rst_n = 1'b1;
        c = cyc;
        push(P_FALL, c + LAT);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == FL + 1 || k == FL + 2) begin
                checks++;
                if (sda_o !== logic'(k == FL + 1))
                    $display("FAIL release_low_sda k=%0d: got %b expected %b", k, sda_o, logic'(k == FL + 1));
                else passes++;
            end
        end
        set_lines(1'b1, 1'b1);
        c = cyc;
        push(P_RISE, c + LAT);
        idle(10);
    endtask

    initial begin
        test_reset();
        test_start();
        test_glitch_clock();
        test_restart_stop();
        test_timeout();
        test_simultaneous();
        test_reset_mid();
        idle(3);
        checks++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: %0d left expected 0", exp_q.size());
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
